// File: rtl/rv32im_fetch_unit.sv
// Fetch stage: owns the fetch PC, keeps one imem request in flight, buffers words+PCs for decode.
// Latency: ack in cycle N shows up on instr_valid_o in N+1; one word per cycle with zero-wait memory.
// Backpressure: no request is issued unless the prefetch FIFO has room; req resumes after the next pop.

module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head is masked by count at the consumer.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

module rv32im_fetch_unit #(
  parameter int                        API_DATA_WIDTH = 32,
  parameter logic [API_DATA_WIDTH-1:0] RESET_PC       = '0,
  parameter int                        FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req_o,
  output logic [API_DATA_WIDTH-1:0] imem_addr_o,
  input  logic                      imem_ack_i,
  input  logic [API_DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                      redirect_i,
  input  logic [API_DATA_WIDTH-1:0] redirect_pc_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [API_DATA_WIDTH-1:0] instruction_o,
  output logic [API_DATA_WIDTH-1:0] pc_o
);
  localparam int                        CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]             DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [API_DATA_WIDTH-1:0] NOP     = API_DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, REQ, REQ_DROP} state_t;

  typedef struct packed {
    logic [API_DATA_WIDTH-1:0] pc;
    logic [API_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

  state_t                    state;
  logic [API_DATA_WIDTH-1:0] fetch_pc;
  logic [API_DATA_WIDTH-1:0] redirect_target;
  logic [CW-1:0]             count;
  logic [CW-1:0]             count_left;
  logic                      pop;
  logic                      push;
  logic                      space;
  logic                      room;
  fetch_entry_t              push_entry;
  fetch_entry_t              head;
  logic                      unused_redirect_lsbs;

  assign pop             = instr_valid_o & instr_ready_i;
  assign count_left      = count - CW'(pop);
  assign space           = count_left < DEPTH_C;
  assign room            = (count_left + 1'b1) < DEPTH_C;
  assign push            = (state == REQ) & imem_ack_i & ~redirect_i;
  assign redirect_target = {redirect_pc_i[API_DATA_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = fetch_pc;
    push_entry.instr = imem_rdata_i;
  end

  fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_i),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .head_dat (head),
    .count    (count)
  );

  assign instr_valid_o = (count != '0);
  assign instruction_o = instr_valid_o ? head.instr : NOP;
  assign pc_o          = instr_valid_o ? head.pc : '0;

  // imem_addr_o only moves when a new request is launched, so it holds while waiting for ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
      fetch_pc    <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= redirect_target;
      case (state)
        REQ: begin
          if (imem_ack_i) begin
            state      <= IDLE;
            imem_req_o <= 1'b0;
          end else begin
            state <= REQ_DROP;
          end
        end
        REQ_DROP: begin
          if (imem_ack_i) begin
            state      <= IDLE;
            imem_req_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (space) begin
            state       <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack_i) begin
            fetch_pc <= fetch_pc + API_DATA_WIDTH'(4);
            if (room) begin
              imem_addr_o <= fetch_pc + API_DATA_WIDTH'(4);
            end else begin
              state      <= IDLE;
              imem_req_o <= 1'b0;
            end
          end
        end
        REQ_DROP: begin
          if (imem_ack_i) begin
            state      <= IDLE;
            imem_req_o <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          imem_req_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rv32im_fetch_unit.sv
// Scoreboarded bench for rv32im_fetch_unit: directed scenarios followed by a randomized stream.
module tb_rv32im_fetch_unit;
  logic        clk           = 1'b0;
  logic        rst           = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i    = 1'b0;
  logic [31:0] imem_rdata_i  = '0;
  logic        redirect_i    = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] model_pc = 32'h100;
  bit          drop_pending = 1'b0;
  logic [31:0] drop_addr = '0;
  bit          mon_en = 1'b0;
  logic [31:0] rnd_tgt;
  int          acks;

  rv32im_fetch_unit #(.RESET_PC(32'h100), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instruction_o (instruction_o),
    .pc_o          (pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // Monitor: every word the decoder takes must be the oldest still-expected word.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (instr_valid_o) begin
        if (instr_ready_i) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_instr: got pc 0x%08h, expected no delivery", pc_o);
          end else begin
            mon_e = exp_q.pop_front();
            check("deliver_pc", pc_o, mon_e.pc);
            check("deliver_instr", instruction_o, mon_e.instr);
          end
        end
      end else begin
        check("empty_instr", instruction_o, 32'h0000_0013);
        check("empty_pc", pc_o, 32'h0);
      end
    end
  end

  // One cycle of stimulus, applied 1 time unit after the rising edge.
  task automatic step(input bit want_ack, input bit rdy, input bit redir, input logic [31:0] tgt);
    bit          hold;
    logic [31:0] held_addr;
    exp_t        e;
    imem_ack_i    = want_ack;
    imem_rdata_i  = mem_word(imem_addr_o);
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    if (imem_req_o && want_ack) begin
      if (drop_pending) begin
        check("drop_addr", imem_addr_o, drop_addr);
        drop_pending = 1'b0;
      end else if (!redir) begin
        check("req_addr", imem_addr_o, model_pc);
        e.pc    = model_pc;
        e.instr = mem_word(model_pc);
        exp_q.push_back(e);
        model_pc = model_pc + 32'd4;
      end
    end
    if (redir) begin
      if (imem_req_o && !want_ack && !drop_pending) begin
        drop_pending = 1'b1;
        drop_addr    = imem_addr_o;
      end
      model_pc = {tgt[31:2], 2'b00};
    end
    hold      = imem_req_o && !want_ack;
    held_addr = imem_addr_o;
    @(posedge clk); #1;
    if (redir) exp_q.delete();
    if (hold) begin
      check("req_hold", imem_req_o, 32'd1);
      check("addr_hold", imem_addr_o, held_addr);
    end
  endtask

  task automatic wait_req(input bit rdy, input logic [31:0] want);
    int n;
    n = 0;
    while (!imem_req_o && n < 8) begin
      step(1'b0, rdy, 1'b0, 32'h0);
      n++;
    end
    check("refetch_req", imem_req_o, 32'd1);
    check("refetch_addr", imem_addr_o, want);
  endtask

  initial begin
    // Reset and first fetch
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", imem_req_o, 32'd0);
    check("rst_addr", imem_addr_o, 32'h100);
    check("rst_valid", instr_valid_o, 32'd0);
    check("rst_instr", instruction_o, 32'h13);
    check("rst_pc", pc_o, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    check("req_before_edge1", imem_req_o, 32'd0);
    @(posedge clk); #1;
    check("first_req", imem_req_o, 32'd1);
    check("first_addr", imem_addr_o, 32'h100);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("latency_valid", instr_valid_o, 32'd1);
    check("latency_pc", pc_o, 32'h100);
    for (int i = 0; i < 6; i++) begin
      check("tput_req", imem_req_o, 32'd1);
      check("tput_valid", instr_valid_o, 32'd1);
      step(1'b1, 1'b1, 1'b0, 32'h0);
    end

    // Backpressure fill from 0x0, entered via a redirect coincident with ack
    step(1'b1, 1'b0, 1'b1, 32'h0);
    check("flush_valid", instr_valid_o, 32'd0);
    wait_req(1'b0, 32'h0);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req_o) begin
        step(1'b1, 1'b0, 1'b0, 32'h0);
        acks++;
      end
    end
    check("bp_acks", acks, 32'd4);
    check("bp_req_low", imem_req_o, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("bp_ack_ignored_req", imem_req_o, 32'd0);
      check("bp_full_valid", instr_valid_o, 32'd1);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("bp_resume_req", imem_req_o, 32'd1);
    check("bp_resume_addr", imem_addr_o, 32'h10);

    // Redirect while a request is pending; late data must be dropped
    step(1'b0, 1'b1, 1'b1, 32'h2003);
    check("pend_flush_valid", instr_valid_o, 32'd0);
    check("pend_held_addr", imem_addr_o, 32'h10);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("pend_drop_valid", instr_valid_o, 32'd0);
    wait_req(1'b1, 32'h2000);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coincident with ack
    step(1'b1, 1'b0, 1'b1, 32'h40);
    check("coinc_valid", instr_valid_o, 32'd0);
    wait_req(1'b0, 32'h40);

    // Async reset with three buffered words and a request active
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("pre_rst_req", imem_req_o, 32'd1);
    check("pre_rst_valid", instr_valid_o, 32'd1);
    imem_ack_i    = 1'b1;
    imem_rdata_i  = mem_word(imem_addr_o);
    instr_ready_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_req", imem_req_o, 32'd0);
    check("arst_addr", imem_addr_o, 32'h100);
    check("arst_valid", instr_valid_o, 32'd0);
    check("arst_instr", instruction_o, 32'h13);
    check("arst_pc", pc_o, 32'h0);
    exp_q.delete();
    model_pc     = 32'h100;
    drop_pending = 1'b0;
    @(posedge clk); #1;
    imem_ack_i = 1'b0;
    rst        = 1'b0;
    check("post_rst_req_low", imem_req_o, 32'd0);
    @(posedge clk); #1;
    check("restart_req", imem_req_o, 32'd1);
    check("restart_addr", imem_addr_o, 32'h100);

    // PC wrap-around
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    wait_req(1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_next_addr", imem_addr_o, 32'h0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic with alternating/random ready and occasional redirects
    for (int i = 0; i < 400; i++) begin
      rnd_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step($urandom_range(0, 99) < 65,
           (i % 2 == 0) ? 1'b1 : ($urandom_range(0, 1) == 1),
           $urandom_range(0, 99) < 4,
           rnd_tgt);
    end

    repeat (10) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_valid", instr_valid_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rv32im_fetch_unit.md
# rv32im_fetch_unit

Instruction fetch stage for the rv32im core. It owns the fetch PC and issues word requests to instruction memory over a req/ack handshake. It buffers returned words with their PCs in a small prefetch FIFO and presents them to `rv32im_decoder_and_cu` through a valid/ready handshake. Redirects from the branch unit flush the buffer and restart fetch at the target.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `FIFO_DEPTH`, default 4: prefetch entries. Must be a power of 2 and ≥ 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `imem_req_o`, out, 1: fetch request.
- `imem_addr_o`, out, `API_DATA_WIDTH`: word address; bits [1:0] are always 0.
- `imem_ack_i`, in, 1: request accepted; data is valid in this same cycle.
- `imem_rdata_i`, in, `API_DATA_WIDTH`: fetched instruction word.
- `redirect_i`, in, 1: branch/jump taken; flush and refetch.
- `redirect_pc_i`, in, `API_DATA_WIDTH`: new fetch PC. Bits [1:0] are ignored (forced to 0).
- `instr_valid_o`, out, 1: FIFO head is valid.
- `instr_ready_i`, in, 1: decoder consumes the head.
- `instruction_o`, out, `API_DATA_WIDTH`: head instruction word.
- `pc_o`, out, `API_DATA_WIDTH`: PC of the head instruction.

## Operation

- **Memory handshake**
  - Once `imem_req_o` is high, `imem_req_o` and `imem_addr_o` stay stable until the cycle in which `imem_ack_i` is high.
  - An ack in the first req cycle is legal.
  - At most one request is outstanding at any time.
  - `imem_ack_i` while `imem_req_o` is low is ignored.
- **State machine** (registered state):
  - IDLE: no request outstanding.
  - REQ: request outstanding; the response will be pushed.
  - REQ_DROP: request outstanding; the response will be discarded.
- **Issue condition:** `space = (count − pop) < FIFO_DEPTH`, where `pop = instr_valid_o & instr_ready_i`.
- **Transitions**
  - IDLE → REQ when space is available and `redirect_i` is low. Address = `fetch_pc`.
  - REQ, ack:
    - Push {`fetch_pc`, `imem_rdata_i`}; `fetch_pc` += 4.
    - Stay in REQ with the new address if `(count + 1 − pop) < FIFO_DEPTH`; otherwise go to IDLE.
  - REQ, no ack, `redirect_i` high → REQ_DROP.
  - REQ_DROP, ack → data discarded; go to IDLE.
- **Redirect**, evaluated at the clock edge:
  - FIFO is flushed (count = 0).
  - `fetch_pc` ← {`redirect_pc_i`[31:2], 2'b00}.
  - In IDLE: go to IDLE; issue at the earliest on the next cycle.
  - In REQ with ack in the same cycle: the acked data is discarded, no push; go to IDLE.
  - In REQ without ack: go to REQ_DROP. The held address stays the old one.
  - A pop in the redirect cycle has no additional effect.
  - A repeated redirect in REQ_DROP updates `fetch_pc` only.
- **FIFO**
  - Circular, with read/write pointers of `$clog2(FIFO_DEPTH)` bits that wrap naturally.
  - Count range 0..`FIFO_DEPTH`.
  - Simultaneous push and pop: count unchanged.
  - Push when full cannot occur, because the issue rule forbids it.
- **Outputs**
  - `instr_valid_o` = (count ≠ 0).
  - When empty: `instruction_o` = 32'h0000_0013 (NOP) and `pc_o` = 0.
- **PC arithmetic:** `fetch_pc` + 4 wraps modulo 2^32 with no flag.

## Timing

- **Reset values**
  - `imem_req_o` = 0, `imem_addr_o` = `RESET_PC`.
  - `instr_valid_o` = 0, `instruction_o` = 32'h0000_0013, `pc_o` = 0.
  - State IDLE, count 0, `fetch_pc` = `RESET_PC`.
- **Reset mid-operation:** all state clears immediately (asynchronously). An in-flight ack in the reset cycle is lost. Memory must tolerate `imem_req_o` dropping without an ack.
- **First request:** `imem_req_o` rises on the first rising edge after `rst` deasserts.
- **Latency:** from ack cycle N, `instr_valid_o` is high in cycle N+1.
- **Throughput:** with zero-wait memory and `instr_ready_i` held high, one instruction per cycle and `imem_req_o` stays high continuously.
- **Redirect to refetch:**
  - Redirect in cycle R, in IDLE or acked in R: new req in cycle R+1.
  - From REQ_DROP: new req in the cycle after the drop-ack.
- **Backpressure:** after `FIFO_DEPTH` instructions are buffered with `instr_ready_i` low, `imem_req_o` is low. Req reasserts the cycle after the first pop.

## Test plan

- **Reset and first fetch:** `RESET_PC` = 32'h100, zero-wait ack, ready = 1.
  - Req rises on edge 1 with addr 0x100.
  - `instr_valid_o` rises the next cycle with `pc_o` = 0x100, followed by 0x104, 0x108 on consecutive cycles.
- **Backpressure fill:** ready = 0, zero-wait memory.
  - After 4 acks (0x0, 0x4, 0x8, 0xC), `imem_req_o` = 0 and count = 4.
  - Ready = 1 for one cycle: pops 0x0; req reasserts with addr 0x10.
- **Redirect while pending:** ack delayed 3 cycles on addr 0x8; redirect to 32'h2003 in cycle 1 of the wait.
  - Held addr stays 0x8; the late data is dropped and `instr_valid_o` stays 0.
  - Next req addr is 0x2000; first delivered `pc_o` = 0x2000.
- **Redirect coincident with ack:** ack on 0x4 in the same cycle as redirect to 0x40.
  - 0x4 is never delivered; FIFO is empty.
  - Next req is 0x40 on the following cycle.
- **Async reset mid-stream:** assert `rst` between edges with count = 3 and REQ active.
  - Outputs go to reset values before the next edge.
  - After release, fetch restarts at `RESET_PC`.
- **Wrap-around:** redirect to 32'hFFFF_FFFC.
  - Delivered PCs are 0xFFFF_FFFC then 0x0000_0000.
  - FIFO pointers wrap correctly over 10 or more push/pop cycles with alternating ready.
